// File: rtl/axi2apb_pkg.sv
// Shared APB request/response bundles and AXI response codes for the APB-to-AXI-Lite bridge.
// Types and constants only; there is no logic, latency or backpressure here.
package axi2apb;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/apb2axi_lite.sv
// APB completer bridged to an AXI-Lite requester, one transaction at a time; all outputs registered.
// Latency setup->pready is 3 cycles minimum; AXI ready/valid stalls simply extend the APB wait (pready low).
module apb2axi_lite
  import axi2apb::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    apb_clk,
  input  logic                    apb_rst,
  input  apb_req_t                apb_req,
  input  logic                    apb_sel,
  output apb_resp_t               apb_resp,
  output logic [ADDR_WIDTH-1:0]   aw_addr,
  output logic [2:0]              aw_prot,
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic [DATA_WIDTH/8-1:0] w_strb,
  output logic                    w_valid,
  input  logic                    w_ready,
  input  logic [1:0]              b_resp,
  input  logic                    b_valid,
  output logic                    b_ready,
  output logic [ADDR_WIDTH-1:0]   ar_addr,
  output logic [2:0]              ar_prot,
  output logic                    ar_valid,
  input  logic                    ar_ready,
  input  logic [DATA_WIDTH-1:0]   r_data,
  input  logic [1:0]              r_resp,
  input  logic                    r_valid,
  output logic                    r_ready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              prot_q, prot_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
  logic                    aw_vld_q, aw_vld_d;
  logic                    w_vld_q, w_vld_d;
  logic                    b_rdy_q, b_rdy_d;
  logic                    ar_vld_q, ar_vld_d;
  logic                    r_rdy_q, r_rdy_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

  logic setup, access, addr_oob;

  assign setup    = apb_sel && !apb_req.penable;
  assign access   = apb_sel && apb_req.penable;
  // Any paddr bit above the AXI address space is a decode error.
  assign addr_oob = |(apb_req.paddr >> ADDR_WIDTH);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    prot_d    = prot_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    aw_vld_d  = aw_vld_q;
    w_vld_d   = w_vld_q;
    b_rdy_d   = b_rdy_q;
    ar_vld_d  = ar_vld_q;
    r_rdy_d   = r_rdy_q;
    pready_d  = 1'b0;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          if (addr_oob) begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
          end else begin
            addr_d  = apb_req.paddr[ADDR_WIDTH-1:0];
            prot_d  = apb_req.pprot;
            wdata_d = apb_req.pwdata;
            strb_d  = apb_req.pstrb;
            if (apb_req.pwrite) begin
              state_d  = WR_REQ;
              aw_vld_d = 1'b1;
              w_vld_d  = 1'b1;
            end else begin
              state_d  = RD_REQ;
              ar_vld_d = 1'b1;
            end
          end
        end else if (access) begin
          state_d   = DONE;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          prdata_d  = '0;
        end
      end
      WR_REQ: begin
        aw_vld_d = aw_vld_q && !aw_ready;
        w_vld_d  = w_vld_q && !w_ready;
        if (!aw_vld_d && !w_vld_d) begin
          state_d = WR_RESP;
          b_rdy_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (b_valid) begin
          state_d   = DONE;
          b_rdy_d   = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = (b_resp != RESP_OKAY);
          prdata_d  = '0;
        end
      end
      RD_REQ: begin
        if (ar_ready) begin
          state_d  = RD_RESP;
          ar_vld_d = 1'b0;
          r_rdy_d  = 1'b1;
        end
      end
      RD_RESP: begin
        if (r_valid) begin
          state_d   = DONE;
          r_rdy_d   = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = (r_resp != RESP_OKAY);
          prdata_d  = r_data;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge apb_clk) begin
    if (apb_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      prot_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      aw_vld_q  <= 1'b0;
      w_vld_q   <= 1'b0;
      b_rdy_q   <= 1'b0;
      ar_vld_q  <= 1'b0;
      r_rdy_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      prot_q    <= prot_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      aw_vld_q  <= aw_vld_d;
      w_vld_q   <= w_vld_d;
      b_rdy_q   <= b_rdy_d;
      ar_vld_q  <= ar_vld_d;
      r_rdy_q   <= r_rdy_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign aw_addr          = addr_q;
  assign aw_prot          = prot_q;
  assign aw_valid         = aw_vld_q;
  assign w_data           = wdata_q;
  assign w_strb           = strb_q;
  assign w_valid          = w_vld_q;
  assign b_ready          = b_rdy_q;
  assign ar_addr          = addr_q;
  assign ar_prot          = prot_q;
  assign ar_valid         = ar_vld_q;
  assign r_ready          = r_rdy_q;
  assign apb_resp.pready  = pready_q;
  assign apb_resp.prdata  = prdata_q;
  assign apb_resp.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb2axi_lite.sv
// Directed bench for apb2axi_lite: APB master stimulus pushes expected responses/beats,
// a negedge monitor pops and compares them; a delay-programmable AXI-Lite completer answers.
module tb_apb2axi_lite;
  import axi2apb::*;

  localparam int AW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_req_t        req;
  logic            sel;
  apb_resp_t       resp;
  logic [AW-1:0]   aw_addr, ar_addr;
  logic [2:0]      aw_prot, ar_prot;
  logic            aw_valid, aw_ready, w_valid, w_ready;
  logic [31:0]     w_data, r_data;
  logic [3:0]      w_strb;
  logic [1:0]      b_resp, r_resp;
  logic            b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready;

  apb2axi_lite #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .apb_clk(clk), .apb_rst(rst), .apb_req(req), .apb_sel(sel), .apb_resp(resp),
    .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  b;
    int          cyc;
  } beat_t;

  rsp_t  rsp_q[$];
  beat_t aw_q[$], w_q[$], ar_q[$];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // completer knobs
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_k = RESP_OKAY, rresp_k = RESP_OKAY;
  logic [31:0] rdata_k = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got an unexpected beat, want none (cycle %0d)", name, cyc);
  endtask

  // AXI-Lite completer: each ready/valid rises after the programmed number of cycles
  initial begin
    int aw_c, w_c, b_c, ar_c, r_c;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
    b_valid = 1'b0; b_resp = RESP_OKAY; r_valid = 1'b0; r_resp = RESP_OKAY; r_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (aw_valid === 1'b1) begin aw_ready = (aw_c >= aw_dly); aw_c++; end
      else begin aw_ready = 1'b0; aw_c = 0; end
      if (w_valid === 1'b1) begin w_ready = (w_c >= w_dly); w_c++; end
      else begin w_ready = 1'b0; w_c = 0; end
      if (ar_valid === 1'b1) begin ar_ready = (ar_c >= ar_dly); ar_c++; end
      else begin ar_ready = 1'b0; ar_c = 0; end
      b_resp = bresp_k;
      if (b_ready === 1'b1) begin b_valid = (b_c >= b_dly); b_c++; end
      else begin b_valid = 1'b0; b_c = 0; end
      r_resp = rresp_k;
      r_data = rdata_k;
      if (r_ready === 1'b1) begin r_valid = (r_c >= r_dly); r_c++; end
      else begin r_valid = 1'b0; r_c = 0; end
    end
  end

  // Monitor: every pready and every AXI handshake must match the head of its queue
  initial begin
    rsp_t  e;
    beat_t bt;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (resp.pready === 1'b1) begin
          if (rsp_q.size() == 0) unexpected("pready");
          else begin
            e = rsp_q.pop_front();
            chk("pslverr", 32'(resp.pslverr), 32'(e.err));
            if (e.chk_data) chk("prdata", resp.prdata, e.data);
            chk("pready_cycle", cyc, e.cyc);
          end
        end
        if (aw_valid === 1'b1 && aw_ready === 1'b1) begin
          if (aw_q.size() == 0) unexpected("aw_beat");
          else begin
            bt = aw_q.pop_front();
            chk("aw_addr", 32'(aw_addr), bt.a);
            chk("aw_prot", 32'(aw_prot), 32'(bt.b));
            chk("aw_cycle", cyc, bt.cyc);
          end
        end
        if (w_valid === 1'b1 && w_ready === 1'b1) begin
          if (w_q.size() == 0) unexpected("w_beat");
          else begin
            bt = w_q.pop_front();
            chk("w_data", w_data, bt.a);
            chk("w_strb", 32'(w_strb), 32'(bt.b));
            chk("w_cycle", cyc, bt.cyc);
          end
        end
        if (ar_valid === 1'b1 && ar_ready === 1'b1) begin
          if (ar_q.size() == 0) unexpected("ar_beat");
          else begin
            bt = ar_q.pop_front();
            chk("ar_addr", 32'(ar_addr), bt.a);
            chk("ar_prot", 32'(ar_prot), 32'(bt.b));
            chk("ar_cycle", cyc, bt.cyc);
          end
        end
      end
    end
  end

  task automatic wait_pready();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp.pready !== 1'b1 && n < 60);
    if (resp.pready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL pready_timeout: got no pready within 60 cycles, want pready=1");
    end
  endtask

  // One APB transfer; lat is the hand-computed setup-to-pready cycle count.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot,
                          input logic [31:0] exp_data, input logic exp_err, input logic chk_data,
                          input int lat, input logic axi_exp, input logic no_setup);
    rsp_t  e;
    beat_t bt;
    @(posedge clk);
    #1;
    req.paddr   = addr;
    req.pwrite  = wr;
    req.pwdata  = wdata;
    req.pstrb   = strb;
    req.pprot   = prot;
    req.penable = no_setup;
    sel         = 1'b1;
    e.data = exp_data; e.err = exp_err; e.chk_data = chk_data; e.cyc = cyc + lat;
    rsp_q.push_back(e);
    if (axi_exp) begin
      if (wr) begin
        bt.a = addr; bt.b = {1'b0, prot}; bt.cyc = cyc + 1 + aw_dly; aw_q.push_back(bt);
        bt.a = wdata; bt.b = strb; bt.cyc = cyc + 1 + w_dly; w_q.push_back(bt);
      end else begin
        bt.a = addr; bt.b = {1'b0, prot}; bt.cyc = cyc + 1 + ar_dly; ar_q.push_back(bt);
      end
    end
    if (!no_setup) begin
      @(posedge clk);
      #1;
      req.penable = 1'b1;
    end
    wait_pready();
    @(posedge clk);
    #1;
    sel         = 1'b0;
    req.penable = 1'b0;
  endtask

  initial begin
    beat_t bt;
    int    n;
    req = '0;
    sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_aw_valid", 32'(aw_valid), 32'd0);
    chk("rst_w_valid", 32'(w_valid), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_ar_valid", 32'(ar_valid), 32'd0);
    chk("rst_r_ready", 32'(r_ready), 32'd0);
    chk("rst_pready", 32'(resp.pready), 32'd0);
    chk("rst_pslverr", 32'(resp.pslverr), 32'd0);
    chk("rst_prdata", resp.prdata, 32'd0);
    rst = 1'b0;

    // basic write, all readies immediate
    apb_xfer(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 4'hF, 3'b000, 32'h0, 1'b0, 1'b0, 3, 1'b1, 1'b0);
    // read with r_valid delayed 5 cycles
    rdata_k = 32'hCAFE_F00D; r_dly = 5;
    apb_xfer(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'b010, 32'hCAFE_F00D, 1'b0, 1'b1, 8, 1'b1, 1'b0);
    r_dly = 0;
    // w_ready 3 cycles ahead of aw_ready
    aw_dly = 3;
    apb_xfer(1'b1, 32'h0000_0100, 32'h1234_5678, 4'h5, 3'b001, 32'h0, 1'b0, 1'b0, 6, 1'b1, 1'b0);
    // aw first, w and b late
    aw_dly = 0; w_dly = 2; b_dly = 2;
    apb_xfer(1'b1, 32'h00AB_CDE0, 32'h0F0F_0F0F, 4'h3, 3'b100, 32'h0, 1'b0, 1'b0, 7, 1'b1, 1'b0);
    w_dly = 0; b_dly = 0;
    // write SLVERR
    bresp_k = RESP_SLVERR;
    apb_xfer(1'b1, 32'h0000_0008, 32'h5555_AAAA, 4'hF, 3'b000, 32'h0, 1'b1, 1'b0, 3, 1'b1, 1'b0);
    bresp_k = RESP_OKAY;
    // read SLVERR keeps r_data, ar_ready late
    rresp_k = RESP_SLVERR; rdata_k = 32'h0BAD_F00D; ar_dly = 2;
    apb_xfer(1'b0, 32'h0000_0200, 32'h0, 4'h0, 3'b011, 32'h0BAD_F00D, 1'b1, 1'b1, 5, 1'b1, 1'b0);
    ar_dly = 0;
    rresp_k = RESP_DECERR; rdata_k = 32'h7777_0001;
    apb_xfer(1'b0, 32'h00FF_FFFC, 32'h0, 4'h0, 3'b000, 32'h7777_0001, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    rresp_k = RESP_OKAY;
    // out-of-range address, write and read: immediate error, no AXI traffic
    apb_xfer(1'b1, 32'h0100_0000, 32'h1111_2222, 4'hF, 3'b000, 32'h0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    apb_xfer(1'b0, 32'hFF00_0040, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    // access phase with no preceding setup
    apb_xfer(1'b0, 32'h0000_0044, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, 1'b0, 1, 1'b0, 1'b1);

    // reset while waiting in RD_RESP
    r_dly = 20;
    @(posedge clk);
    #1;
    req.paddr = 32'h0000_0080; req.pwrite = 1'b0; req.pprot = 3'b000; req.penable = 1'b0; sel = 1'b1;
    bt.a = 32'h0000_0080; bt.b = 4'h0; bt.cyc = cyc + 1; ar_q.push_back(bt);
    @(posedge clk);
    #1;
    req.penable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (r_ready !== 1'b1 && n < 20);
    chk("r_ready_before_reset", 32'(r_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1; sel = 1'b0; req.penable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_ar_valid", 32'(ar_valid), 32'd0);
    chk("midrst_r_ready", 32'(r_ready), 32'd0);
    chk("midrst_pready", 32'(resp.pready), 32'd0);
    rst = 1'b0;
    r_dly = 0; rdata_k = 32'h1357_9BDF;
    apb_xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'b000, 32'h1357_9BDF, 1'b0, 1'b1, 3, 1'b1, 1'b0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rsp_q_left", rsp_q.size(), 32'd0);
    chk("aw_q_left", aw_q.size(), 32'd0);
    chk("w_q_left", w_q.size(), 32'd0);
    chk("ar_q_left", ar_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
